// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared lock FSM encoding and requester indices for bram_arbiter
package bram_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } lock_state_e;

    localparam logic REQ_0 = 1'b0;
    localparam logic REQ_1 = 1'b1;

endpackage

// File: rtl/bram.sv
// rtl/bram.sv - single-port read-first block RAM with registered output
module bram #(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 12
) (
    input  logic                     clock,
    input  logic                     ram_enable,
    input  logic                     write_enable,
    input  logic [RAM_ADDR_BITS-1:0] address,
    input  logic [RAM_WIDTH-1:0]     input_data,
    output logic [RAM_WIDTH-1:0]     output_data
);

    logic [RAM_WIDTH-1:0] mem_q [0:(1<<RAM_ADDR_BITS)-1];

    // Contents are never reset so data survives a controller reset.
    always_ff @(posedge clock) begin
        if (ram_enable) begin
            output_data <= mem_q[address];
            if (write_enable) begin
                mem_q[address] <= input_data;
            end
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - two-requester round-robin BRAM arbiter with bounded lock
module bram_arbiter
    import bram_pkg::*;
#(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 12,
    parameter int MAX_LOCK      = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_0,
    input  logic                     we_0,
    input  logic                     lock_0,
    input  logic [RAM_ADDR_BITS-1:0] addr_0,
    input  logic [RAM_WIDTH-1:0]     wdata_0,
    output logic                     gnt_0,
    output logic                     done_0,
    output logic [RAM_WIDTH-1:0]     rdata_0,
    input  logic                     req_1,
    input  logic                     we_1,
    input  logic                     lock_1,
    input  logic [RAM_ADDR_BITS-1:0] addr_1,
    input  logic [RAM_WIDTH-1:0]     wdata_1,
    output logic                     gnt_1,
    output logic                     done_1,
    output logic [RAM_WIDTH-1:0]     rdata_1
);

    localparam int              CNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

    lock_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic                 last_gnt_q, last_gnt_d;
    logic                 done0_q, done0_d, done1_q, done1_d;
    logic [RAM_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                 gnt0, gnt1;

    logic                     ram_enable, ram_we;
    logic [RAM_ADDR_BITS-1:0] ram_addr;
    logic [RAM_WIDTH-1:0]     ram_wdata, ram_rdata;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        if (reset_n) begin
            case (state_q)
                FREE: begin
                    if (req_0 && req_1) begin
                        gnt0 = (last_gnt_q == REQ_1);
                        gnt1 = (last_gnt_q == REQ_0);
                    end else begin
                        gnt0 = req_0;
                        gnt1 = req_1;
                    end
                    // A lock of length one would expire on entry, so it is never entered.
                    if (MAX_LOCK > 1) begin
                        if (gnt0 && lock_0) begin
                            state_d = LOCK0;
                            cnt_d   = CNT_W'(1);
                        end else if (gnt1 && lock_1) begin
                            state_d = LOCK1;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                LOCK0: begin
                    gnt0 = req_0;
                    if (!lock_0 || (gnt0 && cnt_inc == MAX_CNT)) begin
                        state_d = FREE;
                        cnt_d   = '0;
                    end else if (gnt0) begin
                        cnt_d = cnt_inc;
                    end
                end
                LOCK1: begin
                    gnt1 = req_1;
                    if (!lock_1 || (gnt1 && cnt_inc == MAX_CNT)) begin
                        state_d = FREE;
                        cnt_d   = '0;
                    end else if (gnt1) begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = FREE;
                    cnt_d   = '0;
                end
            endcase
            if (gnt0) last_gnt_d = REQ_0;
            if (gnt1) last_gnt_d = REQ_1;
        end
    end

    assign ram_enable = gnt0 | gnt1;
    assign ram_we     = gnt1 ? we_1    : (gnt0 & we_0);
    assign ram_addr   = gnt1 ? addr_1  : addr_0;
    assign ram_wdata  = gnt1 ? wdata_1 : wdata_0;

    always_comb begin
        done0_d  = gnt0;
        done1_d  = gnt1;
        rdata0_d = done0_q ? ram_rdata : rdata0_q;
        rdata1_d = done1_q ? ram_rdata : rdata1_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= FREE;
            cnt_q      <= '0;
            last_gnt_q <= REQ_1;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // Outputs are forced quiet for the whole reset cycle, including an in-flight done.
    assign gnt_0   = gnt0;
    assign gnt_1   = gnt1;
    assign done_0  = done0_q & reset_n;
    assign done_1  = done1_q & reset_n;
    assign rdata_0 = reset_n ? rdata0_d : '0;
    assign rdata_1 = reset_n ? rdata1_d : '0;

    bram #(
        .RAM_WIDTH    (RAM_WIDTH),
        .RAM_ADDR_BITS(RAM_ADDR_BITS)
    ) u_bram (
        .clock       (clock),
        .ram_enable  (ram_enable),
        .write_enable(ram_we),
        .address     (ram_addr),
        .input_data  (ram_wdata),
        .output_data (ram_rdata)
    );

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - directed self-checking bench for bram_arbiter
module tb_bram_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_0, we_0, lock_0, req_1, we_1, lock_1;
    logic [11:0] addr_0, addr_1;
    logic [31:0] wdata_0, wdata_1;
    logic        gnt_0, done_0, gnt_1, done_1;
    logic [31:0] rdata_0, rdata_1;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    bram_arbiter #(.RAM_WIDTH(32), .RAM_ADDR_BITS(12), .MAX_LOCK(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_0(req_0), .we_0(we_0), .lock_0(lock_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .gnt_0(gnt_0), .done_0(done_0), .rdata_0(rdata_0),
        .req_1(req_1), .we_1(we_1), .lock_1(lock_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .gnt_1(gnt_1), .done_1(done_1), .rdata_1(rdata_1)
    );

    task automatic clear_inputs();
        req_0 = 0; we_0 = 0; lock_0 = 0; addr_0 = '0; wdata_0 = '0;
        req_1 = 0; we_1 = 0; lock_1 = 0; addr_1 = '0; wdata_1 = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 0;
        clear_inputs();
        @(negedge clock);
        reset_n = 1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        clear_inputs();
        req_0 = 1;
        @(negedge clock);
        @(negedge clock);
        #1;
        checks++; if (gnt_0 !== 1'b0) $display("FAIL rst_gnt0: got %b want 0", gnt_0); else passes++;
        checks++; if (gnt_1 !== 1'b0) $display("FAIL rst_gnt1: got %b want 0", gnt_1); else passes++;
        checks++; if (done_0 !== 1'b0 || done_1 !== 1'b0) $display("FAIL rst_done: got %b%b want 00", done_0, done_1); else passes++;
        checks++; if (rdata_0 !== 32'h0 || rdata_1 !== 32'h0) $display("FAIL rst_rdata: got %h %h want 0 0", rdata_0, rdata_1); else passes++;
        req_0 = 0;
        @(negedge clock);
        reset_n = 1;
    endtask

    task automatic test_write_read();
        @(negedge clock);
        req_0 = 1; we_0 = 1; addr_0 = 12'd5; wdata_0 = 32'hDEADBEEF;
        #1;
        checks++; if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) $display("FAIL wr_gnt: got %b%b want 10", gnt_0, gnt_1); else passes++;
        @(negedge clock);
        checks++; if (done_0 !== 1'b1) $display("FAIL wr_done0: got %b want 1", done_0); else passes++;
        req_0 = 0; we_0 = 0;
        req_1 = 1; we_1 = 0; addr_1 = 12'd5;
        #1;
        checks++; if (gnt_1 !== 1'b1 || gnt_0 !== 1'b0) $display("FAIL rd_gnt: got %b%b want 01", gnt_0, gnt_1); else passes++;
        @(negedge clock);
        req_1 = 0;
        #1;
        checks++; if (done_1 !== 1'b1 || done_0 !== 1'b0) $display("FAIL rd_done: got %b%b want 01", done_0, done_1); else passes++;
        checks++; if (rdata_1 !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", rdata_1); else passes++;
        @(negedge clock);
        #1;
        checks++; if (done_1 !== 1'b0) $display("FAIL rd_done_pulse: got %b want 0", done_1); else passes++;
        checks++; if (rdata_1 !== 32'hDEADBEEF) $display("FAIL rd_hold: got %h want deadbeef", rdata_1); else passes++;
        checks++; if (gnt_0 !== 1'b0 || gnt_1 !== 1'b0) $display("FAIL idle_gnt: got %b%b want 00", gnt_0, gnt_1); else passes++;
    endtask

    task automatic test_alternate();
        logic exp0;
        logic prev0;
        do_reset();
        req_0 = 1; addr_0 = 12'd5; req_1 = 1; addr_1 = 12'd5;
        prev0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clock);
                checks++; if (done_0 !== prev0 || done_1 !== ~prev0) $display("FAIL alt_done%0d: got %b%b want %b%b", i, done_0, done_1, prev0, ~prev0); else passes++;
            end
            if (i == 4) begin
                req_0 = 0; req_1 = 0;
            end else begin
                exp0 = (i % 2 == 0);
                #1;
                checks++; if (gnt_0 !== exp0 || gnt_1 !== ~exp0) $display("FAIL alt_gnt%0d: got %b%b want %b%b", i, gnt_0, gnt_1, exp0, ~exp0); else passes++;
                prev0 = exp0;
            end
        end
    endtask

    task automatic test_lock();
        @(negedge clock);
        req_0 = 1; lock_0 = 1; req_1 = 1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            checks++; if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) $display("FAIL lock_gnt%0d: got %b%b want 10", i, gnt_0, gnt_1); else passes++;
        end
        @(negedge clock);
        req_0 = 0; lock_0 = 0;
        #1;
        checks++; if (gnt_0 !== 1'b0 || gnt_1 !== 1'b0) $display("FAIL lock_release: got %b%b want 00", gnt_0, gnt_1); else passes++;
        @(negedge clock);
        #1;
        checks++; if (gnt_1 !== 1'b1 || gnt_0 !== 1'b0) $display("FAIL lock_next: got %b%b want 01", gnt_0, gnt_1); else passes++;
        @(negedge clock);
        req_1 = 0;
    endtask

    task automatic test_max_lock();
        int n0;
        n0 = 0;
        @(negedge clock);
        req_0 = 1; lock_0 = 1; req_1 = 1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            if (gnt_0 === 1'b1) n0++;
            checks++; if (gnt_0 !== (i < 8) || gnt_1 !== (i == 8)) $display("FAIL maxlock_gnt%0d: got %b%b want %b%b", i, gnt_0, gnt_1, (i < 8), (i == 8)); else passes++;
        end
        checks++; if (n0 != 8) $display("FAIL maxlock_count: got %0d want 8", n0); else passes++;
        @(negedge clock);
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        req_0 = 1; we_0 = 0; addr_0 = 12'd5;
        #1;
        checks++; if (gnt_0 !== 1'b1) $display("FAIL mid_gnt: got %b want 1", gnt_0); else passes++;
        @(negedge clock);
        reset_n = 0; req_0 = 0;
        #1;
        checks++; if (done_0 !== 1'b0 || rdata_0 !== 32'h0) $display("FAIL mid_inrst: got %b %h want 0 0", done_0, rdata_0); else passes++;
        @(negedge clock);
        reset_n = 1;
        #1;
        checks++; if (done_0 !== 1'b0 || done_1 !== 1'b0) $display("FAIL mid_done: got %b%b want 00", done_0, done_1); else passes++;
        checks++; if (rdata_0 !== 32'h0 || rdata_1 !== 32'h0) $display("FAIL mid_rdata: got %h %h want 0 0", rdata_0, rdata_1); else passes++;
        @(negedge clock);
        req_0 = 1;
        #1;
        checks++; if (gnt_0 !== 1'b1) $display("FAIL mid_regnt: got %b want 1", gnt_0); else passes++;
        @(negedge clock);
        req_0 = 0;
        #1;
        checks++; if (done_0 !== 1'b1 || rdata_0 !== 32'hDEADBEEF) $display("FAIL mid_keep: got %b %h want 1 deadbeef", done_0, rdata_0); else passes++;
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        req_0 = 1; we_0 = 1; addr_0 = 12'd7; wdata_0 = 32'h1;
        #1;
        checks++; if (gnt_0 !== 1'b1) $display("FAIL b2b_gnt1: got %b want 1", gnt_0); else passes++;
        @(negedge clock);
        wdata_0 = 32'h2;
        #1;
        checks++; if (gnt_0 !== 1'b1 || done_0 !== 1'b1) $display("FAIL b2b_gnt2: got %b %b want 1 1", gnt_0, done_0); else passes++;
        @(negedge clock);
        req_0 = 1; we_0 = 0;
        #1;
        checks++; if (done_0 !== 1'b1 || rdata_0 !== 32'h1) $display("FAIL b2b_first: got %b %h want 1 00000001", done_0, rdata_0); else passes++;
        @(negedge clock);
        clear_inputs();
        #1;
        checks++; if (done_0 !== 1'b1 || rdata_0 !== 32'h2) $display("FAIL b2b_final: got %b %h want 1 00000002", done_0, rdata_0); else passes++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_alternate();
        test_lock();
        test_max_lock();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
